alu_responder: RTL and testbench

ALU_RESPONDER -- requirements
Module: alu_responder

---
 rtl/alu_responder.sv | 99 +++++++++
 tb/tb_alu_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_responder.sv
// ALU request/response block: decodes one operation per accepted request and
// queues {result, zero, err, seq} in a small FIFO until the consumer takes it.
module alu_responder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [7:0]  rsp_seq,
  output logic [7:0]  err_count
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. A valid source holds its payload until that edge; ready here depends
  // only on registered state, never on the partner's valid or ready.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic [7:0]  seq;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        new_entry;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [7:0]    seq_cnt;
  logic          push;
  logic          pop;

  assign req_ready = (count < FULL);
  assign rsp_valid = (count != '0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Unknown opcodes (including X/Z) fall through to the default arm.
  always_comb begin
    new_entry     = '0;
    new_entry.seq = seq_cnt;
    case (req_opcode)
      OP_AND:  new_entry.result = req_a & req_b;
      OP_OR:   new_entry.result = req_a | req_b;
      OP_ADD:  new_entry.result = req_a + req_b;
      OP_SUB:  new_entry.result = req_a - req_b;
      default: new_entry.err    = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == 32'h0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      seq_cnt   <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        wptr    <= wptr + AW'(1);
        seq_cnt <= seq_cnt + 8'd1;
        if (new_entry.err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_result = mem[rptr].result;
  assign rsp_zero   = mem[rptr].zero;
  assign rsp_err    = mem[rptr].err;
  assign rsp_seq    = mem[rptr].seq;

endmodule

// File: tb/tb_alu_responder.sv
// Bench for alu_responder: fixed vector table, hand sequences for queue corners,
// and randomized traffic against a queue-based reference model.
module tb_alu_responder;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_opcode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [7:0]  rsp_seq;
  logic [7:0]  err_count;

  alu_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .rsp_seq(rsp_seq), .err_count(err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: entries are {result[31:0], zero, err, seq[7:0]}
  logic [41:0] exp_q[$];
  logic [7:0]  m_seq;
  logic [7:0]  m_err;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [41:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [7:0] s);
    logic [31:0] r;
    logic        e;
    r = 32'h0;
    e = 1'b0;
    if ($isunknown(op))   e = 1'b1;
    else if (op == 4'd0)  r = a & b;
    else if (op == 4'd1)  r = a | b;
    else if (op == 4'd2)  r = a + b;
    else if (op == 4'd6)  r = a - b;
    else                  e = 1'b1;
    return {r, (r == 32'h0), e, s};
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rr);
    req_valid  = v;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    rsp_ready  = rr;
  endtask

  // Check outputs against the model, predict the coming edge, then advance.
  task automatic step();
    logic        push;
    logic        pop;
    logic [41:0] e;
    check("req_ready", 64'(req_ready), 64'(exp_q.size() < DEPTH));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
    check("err_count", 64'(err_count), 64'(m_err));
    if (exp_q.size() != 0)
      check("rsp_head", 64'({rsp_result, rsp_zero, rsp_err, rsp_seq}), 64'(exp_q[0]));
    push = (req_valid === 1'b1) && (exp_q.size() < DEPTH);
    pop  = (rsp_ready === 1'b1) && (exp_q.size() != 0);
    if (rst) begin
      exp_q.delete();
      m_seq = 8'h0;
      m_err = 8'h0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        e = model(req_opcode, req_a, req_b, m_seq);
        exp_q.push_back(e);
        m_seq = m_seq + 8'd1;
        if (e[8] && m_err != 8'hFF) m_err = m_err + 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
    vecs[1]  = '{4'b0110, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[5]  = '{4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{4'b0110, 32'h9,         32'h9,         32'h0,         1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 32'hDEAD_BEEF, 32'h1,         32'h0,         1'b1, 1'b1};
    vecs[9]  = '{4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1};
    vecs[10] = '{4'b0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    exp_q.delete();
    m_seq = 8'h0;
    m_err = 8'h0;
    rst = 1'b0;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_err_count", 64'(err_count), 64'(0));

    // table: each request pushed while the previous is popped (count stays 1)
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      step();
      check("tbl_valid",  64'(rsp_valid),  64'(1));
      check("tbl_result", 64'(rsp_result), 64'(vecs[i].result));
      check("tbl_zero",   64'(rsp_zero),   64'(vecs[i].zero));
      check("tbl_err",    64'(rsp_err),    64'(vecs[i].err));
      check("tbl_seq",    64'(rsp_seq),    64'(i));
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step();
    check("tbl_err_count", 64'(err_count), 64'(2));

    // illegal opcodes: 1111 then unknown, err_count 1 then 2
    do_reset();
    drive(1'b1, 4'b1111, 32'h0, 32'h0, 1'b1);
    step();
    check("ill_f_err", 64'(rsp_err), 64'(1));
    check("ill_f_cnt", 64'(err_count), 64'(1));
    drive(1'b1, 4'bxxxx, 32'h0, 32'h0, 1'b1);
    step();
    check("ill_x_zero", 64'(rsp_zero), 64'(1));
    check("ill_x_result", 64'(rsp_result), 64'(0));
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step();

    // back-pressure: fill, hold, release, third request accepted
    do_reset();
    drive(1'b1, 4'b0110, 32'h5, 32'h7, 1'b0);
    step();
    drive(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    step();
    check("bp_full_ready", 64'(req_ready), 64'(0));
    drive(1'b1, 4'b0001, 32'h0, 32'h0, 1'b0);
    step();
    check("bp_hold_result", 64'(rsp_result), 64'(32'hFFFF_FFFE));
    check("bp_hold_seq", 64'(rsp_seq), 64'(0));
    rsp_ready = 1'b1;
    step();
    check("bp_second_result", 64'(rsp_result), 64'(32'h00F0_00F0));
    check("bp_second_seq", 64'(rsp_seq), 64'(1));
    check("bp_ready_back", 64'(req_ready), 64'(1));
    step();
    check("bp_third_seq", 64'(rsp_seq), 64'(2));
    check("bp_third_zero", 64'(rsp_zero), 64'(1));
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step();

    // sequence wrap over 257 requests, then err_count saturation
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 4'b0010, 32'(i), 32'h1, 1'b1);
      step();
    end
    check("wrap_seq", 64'(rsp_seq), 64'(0));
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b1010, 32'(i), 32'h3, 1'b1);
      step();
    end
    check("err_sat", 64'(err_count), 64'(8'hFF));
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step();

    // reset while full with a request pending
    do_reset();
    drive(1'b1, 4'b1100, 32'h1, 32'h2, 1'b0);
    step();
    drive(1'b1, 4'b0001, 32'h1, 32'h2, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_full_valid", 64'(rsp_valid), 64'(0));
    check("rst_full_ready", 64'(req_ready), 64'(1));
    check("rst_full_errcnt", 64'(err_count), 64'(0));
    drive(1'b1, 4'b0001, 32'h3, 32'h4, 1'b0);
    step();
    check("rst_full_seq", 64'(rsp_seq), 64'(0));
    check("rst_full_result", 64'(rsp_result), 64'(32'h7));

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 4))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b0110;
        default: op = 4'($urandom_range(0, 15));
      endcase
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), op,
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom(),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
            ($urandom_range(0, 2) != 0));
      step();
    end
    rst = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step();
    step();
    step();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
